vc_eject_buffer: RTL and testbench

VC_EJECT_BUFFER -- requirements
Module: vc_eject_buffer

---
 rtl/vc_eject_buffer.sv | 135 +++++++++++++
 tb/tb_vc_eject_buffer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_eject_buffer.sv
// vc_eject_buffer
//   Ejection buffer at a router output port. Incoming flits carry a one-hot
//   virtual-channel tag and are written into one FIFO per VC. Each VC is
//   drained independently by its own consumer through a valid/ready
//   handshake, so a stalled VC never blocks the others.
//
//   Optional feature: define VC_EJECT_STATS_EN to add per-VC 32-bit counters
//   of accepted flits on port stat_o.
//
// Ports
//   clk      in   single clock, rising edge
//   rstn     in   asynchronous active-low reset
//   vc_i     in   [VN]      one-hot VC tag of the incoming flit
//   data_i   in   [DW]      incoming flit payload
//   valid_i  in             incoming flit valid
//   ready_o  out            buffer accepts the presented flit
//   data_o   out  [VN]x[DW] head flit of each VC FIFO
//   valid_o  out  [VN]      per-VC FIFO non-empty
//   ready_i  in   [VN]      per-VC consumer ready
//   err_o    out            sticky flag, set by a valid flit with an illegal tag
//   stat_o   out  [VN]x32   accepted-flit count per VC (VC_EJECT_STATS_EN only)

`ifndef VN
`define VN 4
`endif
`ifndef DW
`define DW 8
`endif

module vc_eject_buffer #(
    parameter int VN    = `VN,
    parameter int DW    = `DW,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [VN-1:0] vc_i,
    input  logic [DW-1:0] data_i,
    input  logic          valid_i,
    output logic          ready_o,
    output logic [DW-1:0] data_o [VN],
    output logic [VN-1:0] valid_o,
    input  logic [VN-1:0] ready_i,
`ifdef VC_EJECT_STATS_EN
    output logic [31:0]   stat_o [VN],
`endif
    output logic          err_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic          legal;
    logic [VN-1:0] full_v;
    logic [VN-1:0] pop_v;
    logic [VN-1:0] push_v;
    logic          full_sel;
    logic          pop_sel;
    logic          err_q;

    assign legal = $onehot(vc_i);

    // The tag is one-hot when legal, so AND-OR reduction selects the
    // target FIFO's flags without an index decode.
    assign full_sel = |(vc_i & full_v);
    assign pop_sel  = |(vc_i & pop_v);

    // Illegal tags are always "accepted" so the upstream port never stalls
    // on a flit that will be dropped anyway.
    assign ready_o = !legal || !full_sel || pop_sel;

    assign push_v = {VN{valid_i && ready_o && legal}} & vc_i;
    assign pop_v  = valid_o & ready_i;

    for (genvar v = 0; v < VN; v++) begin : g_vc
        logic [PW-1:0] wr_ptr_q;
        logic [PW-1:0] rd_ptr_q;
        logic [CW-1:0] cnt_q;
        logic [DW-1:0] mem_q [DEPTH];

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                // DEPTH is a power of two, so pointers wrap by overflow.
                if (push_v[v]) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop_v[v])  rd_ptr_q <= rd_ptr_q + 1'b1;
                case ({push_v[v], pop_v[v]})
                    2'b10:   cnt_q <= cnt_q + 1'b1;
                    2'b01:   cnt_q <= cnt_q - 1'b1;
                    default: cnt_q <= cnt_q;
                endcase
            end
        end

        // Storage is not reset; its contents are meaningless while cnt_q is 0.
        always_ff @(posedge clk) begin
            if (push_v[v]) mem_q[wr_ptr_q] <= data_i;
        end

        // Head is a mux over storage flops: no path from data_i, and a flit
        // written this cycle becomes visible only after the clock edge.
        assign data_o[v]  = mem_q[rd_ptr_q];
        assign valid_o[v] = (cnt_q != '0);
        assign full_v[v]  = (cnt_q == CW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else if (valid_i && !legal) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;

`ifdef VC_EJECT_STATS_EN
    logic [31:0] stat_q [VN];

    for (genvar v = 0; v < VN; v++) begin : g_stat
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                stat_q[v] <= '0;
            end else if (push_v[v]) begin
                stat_q[v] <= stat_q[v] + 32'd1;
            end
        end
        assign stat_o[v] = stat_q[v];
    end
`endif

endmodule

// File: tb/tb_vc_eject_buffer.sv
`ifndef VN
`define VN 4
`endif
`ifndef DW
`define DW 8
`endif

module tb_vc_eject_buffer;

    localparam int NV = 4;
    localparam int NW = 8;
    localparam int ND = 4;

    logic          clk;
    logic          rstn;
    logic [NV-1:0] vc_i;
    logic [NW-1:0] data_i;
    logic          valid_i;
    logic          ready_o;
    logic [NW-1:0] data_o [NV];
    logic [NV-1:0] valid_o;
    logic [NV-1:0] ready_i;
    logic          err_o;
`ifdef VC_EJECT_STATS_EN
    logic [31:0]   stat_o [NV];
`endif

    vc_eject_buffer #(.VN(NV), .DW(NW), .DEPTH(ND)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .vc_i    (vc_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
`ifdef VC_EJECT_STATS_EN
        .stat_o  (stat_o),
`endif
        .err_o   (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [NW-1:0] exp_q [NV][$];
    int            acc_cnt [NV];
    int            rcv_cnt [NV];
    logic          err_exp;
    logic [NV-1:0] m_full;
    logic [NV-1:0] m_pop;
    logic          exp_rdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    function automatic int total();
        int t = 0;
        for (int v = 0; v < NV; v++) t += exp_q[v].size();
        return t;
    endfunction

    task automatic clear_model();
        for (int v = 0; v < NV; v++) begin
            exp_q[v].delete();
            acc_cnt[v] = 0;
            rcv_cnt[v] = 0;
        end
        err_exp = 1'b0;
    endtask

    // Scoreboard monitor: sampled on the falling edge, between drive and capture.
    always @(negedge clk) begin
        if (rstn) begin
            for (int v = 0; v < NV; v++) begin
                chk($sformatf("valid_o[%0d]", v), 32'(valid_o[v]), 32'(exp_q[v].size() != 0));
                m_full[v] = (exp_q[v].size() >= ND);
                m_pop[v]  = (exp_q[v].size() != 0) && ready_i[v];
            end
            chk("err_o", 32'(err_o), 32'(err_exp));
            for (int v = 0; v < NV; v++) begin
                if (m_pop[v]) begin
                    chk($sformatf("data_o[%0d]", v), 32'(data_o[v]), 32'(exp_q[v].pop_front()));
                    rcv_cnt[v]++;
                end
            end
            if (valid_i) begin
                if ($onehot(vc_i)) begin
                    exp_rdy = 1'b0;
                    for (int v = 0; v < NV; v++)
                        if (vc_i[v]) exp_rdy = !m_full[v] || m_pop[v];
                    chk("ready_o", 32'(ready_o), 32'(exp_rdy));
                    if (ready_o) begin
                        for (int v = 0; v < NV; v++) begin
                            if (vc_i[v]) begin
                                exp_q[v].push_back(data_i);
                                acc_cnt[v]++;
                            end
                        end
                    end
                end else begin
                    chk("ready_o_illegal", 32'(ready_o), 32'd1);
                    err_exp = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [NV-1:0] vc, input logic [NW-1:0] d, input bit rnd);
        bit acc = 1'b0;
        int n = 0;
        vc_i    = vc;
        data_i  = d;
        valid_i = 1'b1;
        while (!acc && n < 200) begin
            if (rnd) ready_i = 4'($urandom_range(15));
            @(negedge clk);
            acc = ready_o;
            tick();
            n++;
        end
        valid_i = 1'b0;
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        ready_i = '1;
        while (total() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_empty", 32'(total()), 32'd0);
    endtask

    int sent [NV];
    int pick;

    initial begin
        rstn    = 1'b0;
        vc_i    = 4'b0001;
        data_i  = '0;
        valid_i = 1'b0;
        ready_i = '1;
        clear_model();
        #1;
        chk("rst_valid_o", 32'(valid_o), 32'd0);
        chk("rst_err_o", 32'(err_o), 32'd0);
        chk("rst_ready_o", 32'(ready_o), 32'd1);
        tick();
        tick();
        rstn = 1'b1;
        tick();

        // Single flit: visible exactly one cycle after the push, then gone.
        vc_i = 4'b0100; data_i = 8'hA5; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        chk("single_valid", 32'(valid_o[2]), 32'd1);
        chk("single_data", 32'(data_o[2]), 32'hA5);
        tick();
        chk("single_gone", 32'(valid_o[2]), 32'd0);

        // Fill VC1 with its consumer stalled; fifth flit rides on the first pop.
        ready_i = 4'b1101;
        for (int i = 0; i < 4; i++) send(4'b0010, 8'h10 + 8'(i), 1'b0);
        vc_i = 4'b0010; data_i = 8'h14; valid_i = 1'b1;
        @(negedge clk);
        chk("fill_full_rdy", 32'(ready_o), 32'd0);
        tick();
        ready_i[1] = 1'b1;
        @(negedge clk);
        chk("fill_pop_rdy", 32'(ready_o), 32'd1);
        tick();
        valid_i = 1'b0;
        drain();

        // Isolation: VC0 full and stalled must not block VC3.
        ready_i = 4'b1110;
        for (int i = 0; i < 4; i++) send(4'b0001, 8'h20 + 8'(i), 1'b0);
        vc_i = 4'b1000; data_i = 8'h30; valid_i = 1'b1;
        @(negedge clk);
        chk("iso_rdy", 32'(ready_o), 32'd1);
        tick();
        valid_i = 1'b0;
        for (int i = 1; i < 3; i++) send(4'b1000, 8'h30 + 8'(i), 1'b0);
        tick();
        tick();
        chk("iso_vc3_rcv", 32'(rcv_cnt[3]), 32'd3);
        chk("iso_vc0_held", 32'(valid_o[0]), 32'd1);
        drain();

        // Illegal tags: accepted and dropped, error sticks.
        vc_i = 4'b0000; data_i = 8'hEE; valid_i = 1'b1;
        tick();
        vc_i = 4'b0011;
        tick();
        valid_i = 1'b0;
        vc_i = 4'b0001;
        for (int i = 0; i < 4; i++) tick();
        chk("illegal_err_sticky", 32'(err_o), 32'd1);
        chk("illegal_no_valid", 32'(valid_o), 32'd0);

        // Reset with three flits parked in VC2.
        ready_i = 4'b1011;
        for (int i = 0; i < 3; i++) send(4'b0100, 8'h40 + 8'(i), 1'b0);
        vc_i = 4'b0100;
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid_o", 32'(valid_o), 32'd0);
        chk("mid_rst_err_o", 32'(err_o), 32'd0);
        chk("mid_rst_ready_o", 32'(ready_o), 32'd1);
        clear_model();
        tick();
        tick();
        rstn = 1'b1;
        ready_i = '1;
        send(4'b0100, 8'h3C, 1'b0);
        tick();
        tick();
        chk("post_rst_rcv", 32'(rcv_cnt[2]), 32'd1);
        chk("post_rst_valid_o", 32'(valid_o), 32'd0);

        // Random soak: 1000 flits per VC with random consumer back-pressure.
        for (int v = 0; v < NV; v++) begin
            sent[v] = 0;
            rcv_cnt[v] = 0;
        end
        for (int k = 0; k < NV * 1000; k++) begin
            do pick = $urandom_range(NV - 1); while (sent[pick] >= 1000);
            sent[pick]++;
            if ($urandom_range(3) == 0) begin
                ready_i = 4'($urandom_range(15));
                tick();
            end
            send(4'(1 << pick), 8'($urandom_range(255)), 1'b1);
        end
        drain();
        tick();
        for (int v = 0; v < NV; v++) begin
            chk($sformatf("soak_rcv[%0d]", v), 32'(rcv_cnt[v]), 32'd1000);
`ifdef VC_EJECT_STATS_EN
            chk($sformatf("stat_o[%0d]", v), stat_o[v], 32'(acc_cnt[v]));
            chk($sformatf("stat_abs[%0d]", v), stat_o[v], (v == 2) ? 32'd1001 : 32'd1000);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
